noc_vc_input_port: RTL and testbench
====================================

NOC_VC_INPUT_PORT -- requirements
Module: noc_vc_input_port

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of virtual channels (1..8); VC_W = max(1, clog2(CHANNELS)).
REQ-002 SHALL have parameter DEPTH, default 4, flit slots per VC FIFO (power of 2, >=2).
REQ-003 SHALL have parameter FLIT_W, default 64, flit payload width.
REQ-004 SHALL have parameters X_W, default 4, and Y_W, default 4, router coordinate widths.
REQ-005 SHALL have parameter ROUTE_MODE, default 0, dimension order: 0 = XY, 1 = YX.
REQ-006 SHALL have parameter ACTIVATE_PORT, default 5'b11111, legal output ports; bit index = port code.
REQ-007 SHALL have port noc_clk  in  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port noc_rst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have ports id_x  in  X_W and id_y  in  Y_W  router coordinates, quasi-static.
REQ-010 SHALL have ports in_valid  in  1, in_vc  in  VC_W, in_head  in  1, in_tail  in  1, in_data  in  FLIT_W  upstream flit write; no ready, credit flow control.
REQ-011 SHALL have port credit_out  out  CHANNELS  one-cycle pulse per VC per flit freed.
REQ-012 SHALL have ports out_valid  out  CHANNELS, out_port  out  3*CHANNELS, out_data  out  FLIT_W*CHANNELS, out_head  out  CHANNELS, out_tail  out  CHANNELS  per-VC switch request plus front flit.
REQ-013 SHALL have port out_ready  in  CHANNELS  switch grant; transfer when out_valid[v] & out_ready[v].
REQ-014 SHALL have ports route_err  out  1, proto_err  out  1, ovf_err  out  1  one-cycle error pulses.

Function
REQ-015 SHALL encode ports as LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4; dest_x = head in_data[X_W+Y_W-1:Y_W], dest_y = head in_data[Y_W-1:0].
REQ-016 SHALL route XY: dest_x>id_x EAST, dest_x<id_x WEST, else dest_y>id_y NORTH, dest_y<id_y SOUTH, else LOCAL; YX: Y compared first, then X.
REQ-017 SHALL write a flit into FIFO[in_vc] when in_valid=1 and that FIFO is not full at cycle start; a same-cycle pop does not free space for that push.
REQ-018 SHALL, on in_valid to a full VC or in_vc >= CHANNELS, drop the flit, pulse ovf_err next cycle, leave FIFO contents unchanged.
REQ-019 SHALL run one FSM per VC: IDLE, ACTIVE, DROP.
REQ-020 SHALL, in IDLE with a head flit at the FIFO front, compute the route, register it into out_port[v], and enter ACTIVE at the next edge without popping.
REQ-021 SHALL, in IDLE with a computed port whose ACTIVATE_PORT bit is 0, enter DROP instead and pulse route_err next cycle.
REQ-022 SHALL, in IDLE with a non-head flit at the front, pop and discard it, pulse proto_err and credit_out[v] next cycle, remain IDLE.
REQ-023 SHALL, in ACTIVE, drive out_valid[v]=1 whenever FIFO[v] is non-empty, with out_data/out_head/out_tail from the front flit and out_port held constant.
REQ-024 SHALL pop on each transfer; transfer of a tail flit returns the VC to IDLE; a head+tail flit is a one-flit packet.
REQ-025 SHALL, in DROP, pop one flit per cycle while non-empty, out_valid[v]=0, and return to IDLE after popping the tail.
REQ-026 SHALL pulse credit_out[v] the cycle after every pop (transfer, DROP, or discard), exactly one pulse per flit.
REQ-027 SHALL give head latency of 2 cycles: in_valid at cycle N, out_valid at cycle N+2; body flits already stored are presented back-to-back with no bubbles.
REQ-028 SHALL keep VCs fully independent; simultaneous pushes to one VC and pops from others never interact.
REQ-029 SHALL hold out_valid/out_data stable while out_valid=1 and out_ready=0.
REQ-030 SHALL use wrap-around read/write pointers with an extra bit for full/empty; full = DEPTH entries.

Reset
REQ-031 SHALL, while noc_rst=1, set all FIFOs empty, all FSMs IDLE, out_valid, credit_out, route_err, proto_err, ovf_err to 0 and out_port to 0.
REQ-032 SHALL, on reset mid-packet, discard all stored flits without credit pulses and ignore in_valid during reset.

Verification
REQ-033 SHALL test id=(2,2), ROUTE_MODE=0, 3-flit packet to dest (4,1) on VC0, out_ready=1 -> out_port=3 (EAST) at N+2, flits on N+2..N+4, 3 credit pulses, back to IDLE.
REQ-034 SHALL test same packet with ROUTE_MODE=1 -> out_port=2 (SOUTH).
REQ-035 SHALL test ACTIVATE_PORT=5'b11110, dest (2,2) -> route_err pulse, no out_valid, all flits dropped with 3 credits.
REQ-036 SHALL test DEPTH=4, 5 flits to VC1 with out_ready=0 -> 5th dropped, ovf_err pulse, 4 flits later delivered in order.
REQ-037 SHALL test body flit to idle VC0 -> proto_err pulse, 1 credit, VC0 stays IDLE; and reset asserted mid-packet -> all outputs 0, no credits.

Source files
------------

// File: rtl/noc_vc_input_port.sv
// NoC router input port with per-virtual-channel flit FIFOs.
// Each VC owns a FIFO and a small IDLE/ACTIVE/DROP state machine. The route
// is computed once, from the head flit, and held for the rest of the packet.
// Upstream flow control is credit based: one credit is returned per flit freed.

module noc_vc_input_port #(
    parameter int         CHANNELS      = 2,
    parameter int         DEPTH         = 4,
    parameter int         FLIT_W        = 64,
    parameter int         X_W           = 4,
    parameter int         Y_W           = 4,
    parameter int         ROUTE_MODE    = 0,
    parameter logic [4:0] ACTIVATE_PORT = 5'b11111,
    localparam int        VC_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         noc_clk,
    input  logic                         noc_rst,
    input  logic [X_W-1:0]               id_x,
    input  logic [Y_W-1:0]               id_y,
    input  logic                         in_valid,
    input  logic [VC_W-1:0]              in_vc,
    input  logic                         in_head,
    input  logic                         in_tail,
    input  logic [FLIT_W-1:0]            in_data,
    output logic [CHANNELS-1:0]          credit_out,
    output logic [CHANNELS-1:0]          out_valid,
    output logic [3*CHANNELS-1:0]        out_port,
    output logic [FLIT_W*CHANNELS-1:0]   out_data,
    output logic [CHANNELS-1:0]          out_head,
    output logic [CHANNELS-1:0]          out_tail,
    input  logic [CHANNELS-1:0]          out_ready,
    output logic                         route_err,
    output logic                         proto_err,
    output logic                         ovf_err
);

    // FIFO address width; pointers carry one extra wrap bit for full/empty.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Stored entry layout: {head, tail, payload}.
    localparam int EW = FLIT_W + 2;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    // Padded so that any 3-bit port code indexes a defined bit.
    localparam logic [7:0] ACT_MASK = {3'b000, ACTIVATE_PORT};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } vc_state_e;

    // Dimension-ordered routing decision for one head flit.
    function automatic logic [2:0] route_fn(
        input logic [X_W-1:0] dx,
        input logic [Y_W-1:0] dy,
        input logic [X_W-1:0] ix,
        input logic [Y_W-1:0] iy
    );
        logic [2:0] x_port;
        logic [2:0] y_port;
        logic       x_eq;
        logic       y_eq;
        logic [2:0] port;
        x_eq   = (dx == ix);
        y_eq   = (dy == iy);
        x_port = (dx > ix) ? PORT_EAST  : PORT_WEST;
        y_port = (dy > iy) ? PORT_NORTH : PORT_SOUTH;
        if (ROUTE_MODE == 0) begin
            if (!x_eq) begin
                port = x_port;
            end else if (!y_eq) begin
                port = y_port;
            end else begin
                port = PORT_LOCAL;
            end
        end else begin
            if (!y_eq) begin
                port = y_port;
            end else if (!x_eq) begin
                port = x_port;
            end else begin
                port = PORT_LOCAL;
            end
        end
        return port;
    endfunction

    // Storage and state
    logic [EW-1:0]       mem_q      [CHANNELS][DEPTH];
    logic [PW-1:0]       wr_ptr_q   [CHANNELS];
    logic [PW-1:0]       wr_ptr_d   [CHANNELS];
    logic [PW-1:0]       rd_ptr_q   [CHANNELS];
    logic [PW-1:0]       rd_ptr_d   [CHANNELS];
    vc_state_e           state_q    [CHANNELS];
    vc_state_e           state_d    [CHANNELS];
    logic [2:0]          port_q     [CHANNELS];
    logic [2:0]          port_d     [CHANNELS];
    logic [CHANNELS-1:0] credit_q;
    logic [CHANNELS-1:0] credit_d;
    logic                route_err_q;
    logic                route_err_d;
    logic                proto_err_q;
    logic                proto_err_d;
    logic                ovf_err_q;
    logic                ovf_err_d;

    // Per-VC decode
    logic [CHANNELS-1:0] empty_s;
    logic [CHANNELS-1:0] full_s;
    logic [CHANNELS-1:0] push_s;
    logic [CHANNELS-1:0] pop_s;
    logic [CHANNELS-1:0] front_head_s;
    logic [CHANNELS-1:0] front_tail_s;
    logic [CHANNELS-1:0] route_ok_s;
    logic [CHANNELS-1:0] route_fault_s;
    logic [CHANNELS-1:0] proto_s;
    logic [FLIT_W-1:0]   front_data_s [CHANNELS];
    logic [2:0]          route_s      [CHANNELS];
    logic                vc_ok_s;
    logic                sel_full_s;
    logic                ovf_s;

    // FIFO occupancy, front-flit view and route of the front flit per VC.
    always_comb begin
        empty_s      = '0;
        full_s       = '0;
        front_head_s = '0;
        front_tail_s = '0;
        route_ok_s   = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            empty_s[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
            full_s[v]  = (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]) &&
                         (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]);
            {front_head_s[v], front_tail_s[v], front_data_s[v]} =
                mem_q[v][rd_ptr_q[v][AW-1:0]];
            route_s[v] = route_fn(front_data_s[v][X_W+Y_W-1:Y_W],
                                  front_data_s[v][Y_W-1:0], id_x, id_y);
            route_ok_s[v] = ACT_MASK[route_s[v]];
        end
    end

    // Upstream write: accept only into an existing, non-full VC; full is judged
    // on the start-of-cycle pointers so a same-cycle pop never makes room.
    always_comb begin
        push_s     = '0;
        vc_ok_s    = 1'b0;
        sel_full_s = 1'b0;
        for (int v = 0; v < CHANNELS; v++) begin
            if (in_vc == VC_W'(v)) begin
                vc_ok_s    = 1'b1;
                sel_full_s = full_s[v];
            end else begin
                vc_ok_s    = vc_ok_s;
            end
            push_s[v] = in_valid && !noc_rst && (in_vc == VC_W'(v)) && !full_s[v];
        end
        ovf_s = in_valid && !noc_rst && (!vc_ok_s || sel_full_s);
    end

    // Per-VC state machine next state, pop decision and error events.
    always_comb begin
        pop_s         = '0;
        route_fault_s = '0;
        proto_s       = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            state_d[v] = state_q[v];
            port_d[v]  = port_q[v];
            case (state_q[v])
                ST_IDLE: begin
                    if (!empty_s[v]) begin
                        if (front_head_s[v]) begin
                            // Head waits at the front; it is popped by ACTIVE or DROP.
                            port_d[v] = route_s[v];
                            if (route_ok_s[v]) begin
                                state_d[v] = ST_ACTIVE;
                            end else begin
                                state_d[v]       = ST_DROP;
                                route_fault_s[v] = 1'b1;
                            end
                        end else begin
                            // Stray body/tail flit with no open packet: discard it.
                            pop_s[v]   = 1'b1;
                            proto_s[v] = 1'b1;
                            state_d[v] = ST_IDLE;
                        end
                    end else begin
                        state_d[v] = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (!empty_s[v] && out_ready[v]) begin
                        pop_s[v]   = 1'b1;
                        state_d[v] = front_tail_s[v] ? ST_IDLE : ST_ACTIVE;
                    end else begin
                        state_d[v] = ST_ACTIVE;
                    end
                end
                ST_DROP: begin
                    if (!empty_s[v]) begin
                        pop_s[v]   = 1'b1;
                        state_d[v] = front_tail_s[v] ? ST_IDLE : ST_DROP;
                    end else begin
                        state_d[v] = ST_DROP;
                    end
                end
                default: begin
                    state_d[v] = ST_IDLE;
                end
            endcase
        end
    end

    // Pointer advance, credit return and error pulse next-state values.
    always_comb begin
        for (int v = 0; v < CHANNELS; v++) begin
            wr_ptr_d[v] = wr_ptr_q[v] + PW'(push_s[v]);
            rd_ptr_d[v] = rd_ptr_q[v] + PW'(pop_s[v]);
        end
        credit_d    = pop_s;
        route_err_d = |route_fault_s;
        proto_err_d = |proto_s;
        ovf_err_d   = ovf_s;
    end

    // Control registers with synchronous reset; reset empties every FIFO.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            for (int v = 0; v < CHANNELS; v++) begin
                state_q[v]  <= ST_IDLE;
                port_q[v]   <= 3'd0;
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
            credit_q    <= '0;
            route_err_q <= 1'b0;
            proto_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            for (int v = 0; v < CHANNELS; v++) begin
                state_q[v]  <= state_d[v];
                port_q[v]   <= port_d[v];
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
            end
            credit_q    <= credit_d;
            route_err_q <= route_err_d;
            proto_err_q <= proto_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    // Flit storage; contents need no reset since the pointers define validity.
    always_ff @(posedge noc_clk) begin
        for (int v = 0; v < CHANNELS; v++) begin
            if (push_s[v]) begin
                mem_q[v][wr_ptr_q[v][AW-1:0]] <= {in_head, in_tail, in_data};
            end
        end
    end

    // Switch-side view: request only while a packet is open and a flit waits.
    always_comb begin
        out_valid = '0;
        out_port  = '0;
        out_data  = '0;
        out_head  = '0;
        out_tail  = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            out_valid[v]               = (state_q[v] == ST_ACTIVE) && !empty_s[v];
            out_port[3*v +: 3]         = port_q[v];
            out_data[FLIT_W*v +: FLIT_W] = front_data_s[v];
            out_head[v]                = front_head_s[v];
            out_tail[v]                = front_tail_s[v];
        end
    end

    assign credit_out = credit_q;
    assign route_err  = route_err_q;
    assign proto_err  = proto_err_q;
    assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_noc_vc_input_port.sv
// Directed bench for noc_vc_input_port. Three instances share the stimulus:
// [0] XY routing, [1] YX routing, [2] XY with the LOCAL port disabled.
// Delivered flits of instance 0 are checked against a per-VC scoreboard.

module tb_noc_vc_input_port;

    localparam int CH = 2;
    localparam int FW = 64;
    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          noc_rst;
    logic [3:0]    id_x = 4'd2;
    logic [3:0]    id_y = 4'd2;
    logic          in_valid;
    logic [0:0]    in_vc;
    logic          in_head;
    logic          in_tail;
    logic [FW-1:0] in_data;
    logic [CH-1:0] out_ready;

    logic [CH-1:0]    credit_w    [ND];
    logic [CH-1:0]    out_valid_w [ND];
    logic [3*CH-1:0]  out_port_w  [ND];
    logic [FW*CH-1:0] out_data_w  [ND];
    logic [CH-1:0]    out_head_w  [ND];
    logic [CH-1:0]    out_tail_w  [ND];
    logic             route_err_w [ND];
    logic             proto_err_w [ND];
    logic             ovf_err_w   [ND];

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        noc_vc_input_port #(
            .CHANNELS      (CH),
            .DEPTH         (4),
            .FLIT_W        (FW),
            .X_W           (4),
            .Y_W           (4),
            .ROUTE_MODE    ((d == 1) ? 1 : 0),
            .ACTIVATE_PORT ((d == 2) ? 5'b11110 : 5'b11111)
        ) u_dut (
            .noc_clk    (clk),
            .noc_rst    (noc_rst),
            .id_x       (id_x),
            .id_y       (id_y),
            .in_valid   (in_valid),
            .in_vc      (in_vc),
            .in_head    (in_head),
            .in_tail    (in_tail),
            .in_data    (in_data),
            .credit_out (credit_w[d]),
            .out_valid  (out_valid_w[d]),
            .out_port   (out_port_w[d]),
            .out_data   (out_data_w[d]),
            .out_head   (out_head_w[d]),
            .out_tail   (out_tail_w[d]),
            .out_ready  (out_ready),
            .route_err  (route_err_w[d]),
            .proto_err  (proto_err_w[d]),
            .ovf_err    (ovf_err_w[d])
        );
    end

    typedef struct packed {
        logic [63:0] data;
        logic        head;
        logic        tail;
        logic [2:0]  port;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int n_checks;
    int n_errors;
    int cred [ND][CH];
    int rerr [ND];
    int perr [ND];
    int oerr [ND];
    int rm_valid;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int v, input logic [63:0] d, input logic h, input logic t,
                            input logic [2:0] p);
        exp_t e;
        e.data = d;
        e.head = h;
        e.tail = t;
        e.port = p;
        if (v == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
    endtask

    task automatic sb_compare(input int v, input exp_t obs);
        exp_t e;
        int   sz;
        sz = (v == 0) ? sbq0.size() : sbq1.size();
        check("sb_has_entry", 128'(sz != 0), 128'(1'b1));
        if (sz != 0) begin
            if (v == 0) begin
                e = sbq0.pop_front();
                check("sb_flit_vc0", 128'(obs), 128'(e));
            end else begin
                e = sbq1.pop_front();
                check("sb_flit_vc1", 128'(obs), 128'(e));
            end
        end
    endtask

    // Negedge sample: scoreboard transfers of instance 0, tally pulses.
    task automatic sample();
        exp_t obs;
        @(negedge clk);
        for (int v = 0; v < CH; v++) begin
            if (out_valid_w[0][v] && out_ready[v]) begin
                obs.data = out_data_w[0][v*FW +: FW];
                obs.head = out_head_w[0][v];
                obs.tail = out_tail_w[0][v];
                obs.port = out_port_w[0][3*v +: 3];
                sb_compare(v, obs);
            end
            for (int d = 0; d < ND; d++) begin
                cred[d][v] += int'(credit_w[d][v]);
            end
        end
        for (int d = 0; d < ND; d++) begin
            rerr[d] += int'(route_err_w[d]);
            perr[d] += int'(proto_err_w[d]);
            oerr[d] += int'(ovf_err_w[d]);
        end
        if (|out_valid_w[2]) rm_valid++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample();
            adv();
        end
    endtask

    task automatic set_flit(input logic vc, input logic h, input logic t, input logic [63:0] d);
        in_valid = 1'b1;
        in_vc    = vc;
        in_head  = h;
        in_tail  = t;
        in_data  = d;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_vc    = 1'b0;
        in_head  = 1'b0;
        in_tail  = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        logic [63:0] t4_data [5];
        int b0, b1, b2, r0, r2, v2, o0, p0;

        n_checks = 0;
        n_errors = 0;
        rm_valid = 0;
        for (int d = 0; d < ND; d++) begin
            rerr[d] = 0; perr[d] = 0; oerr[d] = 0;
            for (int v = 0; v < CH; v++) cred[d][v] = 0;
        end

        // Reset, with a flit offered that must be ignored
        noc_rst   = 1'b1;
        out_ready = 2'b11;
        set_flit(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0041);
        adv();
        adv();
        sample();
        check("rst_out_valid", 128'(out_valid_w[0]), 128'(0));
        check("rst_credit",    128'(credit_w[0]),    128'(0));
        check("rst_port",      128'(out_port_w[0]),  128'(0));
        check("rst_errs", 128'({route_err_w[0], proto_err_w[0], ovf_err_w[0]}), 128'(0));
        adv();
        noc_rst = 1'b0;
        idle_in();
        run(4);
        check("rst_in_ignored", 128'(out_valid_w[0]), 128'(0));
        check("rst_no_credit",  128'(cred[0][0] + cred[0][1]), 128'(0));

        // 3-flit packet to (4,1) on VC0: XY -> EAST, YX -> SOUTH
        b0 = cred[0][0];
        b1 = cred[1][0];
        set_flit(1'b0, 1'b1, 1'b0, 64'hA5A5_0000_0000_0041);
        push_exp(0, 64'hA5A5_0000_0000_0041, 1'b1, 1'b0, 3'd3);
        sample();
        check("t1_lat_n", 128'(out_valid_w[0][0]), 128'(0));
        adv();
        set_flit(1'b0, 1'b0, 1'b0, 64'hB0D1_0000_0000_0001);
        push_exp(0, 64'hB0D1_0000_0000_0001, 1'b0, 1'b0, 3'd3);
        sample();
        check("t1_lat_n1", 128'(out_valid_w[0][0]), 128'(0));
        adv();
        set_flit(1'b0, 1'b0, 1'b1, 64'hB0D2_0000_0000_0002);
        push_exp(0, 64'hB0D2_0000_0000_0002, 1'b0, 1'b1, 3'd3);
        sample();
        check("t1_valid_n2", 128'(out_valid_w[0][0]), 128'(1));
        check("t1_port_xy",  128'(out_port_w[0][2:0]), 128'(3));
        check("t1_port_yx",  128'(out_port_w[1][2:0]), 128'(2));
        adv();
        idle_in();
        sample();
        check("t1_valid_n3", 128'(out_valid_w[0][0]), 128'(1));
        adv();
        sample();
        check("t1_valid_n4", 128'(out_valid_w[0][0]), 128'(1));
        adv();
        sample();
        check("t1_idle_n5", 128'(out_valid_w[0][0]), 128'(0));
        adv();
        run(2);
        check("t1_credits_xy", 128'(cred[0][0] - b0), 128'(3));
        check("t1_credits_yx", 128'(cred[1][0] - b1), 128'(3));
        check("t1_sb_drained", 128'(sbq0.size()), 128'(0));

        // Packet to (2,2): LOCAL; disabled on instance 2
        b2 = cred[2][0];
        r0 = rerr[0];
        r2 = rerr[2];
        v2 = rm_valid;
        set_flit(1'b0, 1'b1, 1'b0, 64'hC3C3_0000_0000_0022);
        push_exp(0, 64'hC3C3_0000_0000_0022, 1'b1, 1'b0, 3'd0);
        sample();
        adv();
        set_flit(1'b0, 1'b0, 1'b0, 64'hC3C3_0000_0000_0001);
        push_exp(0, 64'hC3C3_0000_0000_0001, 1'b0, 1'b0, 3'd0);
        sample();
        adv();
        set_flit(1'b0, 1'b0, 1'b1, 64'hC3C3_0000_0000_0002);
        push_exp(0, 64'hC3C3_0000_0000_0002, 1'b0, 1'b1, 3'd0);
        sample();
        check("t3_route_err_pulse", 128'(route_err_w[2]), 128'(1));
        check("t3_local_port",      128'(out_port_w[0][2:0]), 128'(0));
        adv();
        idle_in();
        run(5);
        check("t3_drop_credits",  128'(cred[2][0] - b2), 128'(3));
        check("t3_route_err_cnt", 128'(rerr[2] - r2), 128'(1));
        check("t3_no_valid",      128'(rm_valid - v2), 128'(0));
        check("t3_no_err_active", 128'(rerr[0] - r0), 128'(0));
        check("t3_sb_drained",    128'(sbq0.size()), 128'(0));

        // Five flits to VC1 while stalled: fifth overflows
        t4_data[0] = 64'h1111_0000_0000_0041;
        t4_data[1] = 64'h1111_0000_0000_0101;
        t4_data[2] = 64'h1111_0000_0000_0202;
        t4_data[3] = 64'h1111_0000_0000_0303;
        t4_data[4] = 64'h5555_0000_0000_0041;
        out_ready = 2'b01;
        b1 = cred[0][1];
        o0 = oerr[0];
        for (int i = 0; i < 4; i++) begin
            set_flit(1'b1, i == 0, i == 3, t4_data[i]);
            push_exp(1, t4_data[i], i == 0, i == 3, 3'd3);
            sample();
            adv();
        end
        set_flit(1'b1, 1'b1, 1'b0, t4_data[4]);
        sample();
        check("t4_no_ovf_early", 128'(ovf_err_w[0]), 128'(0));
        adv();
        idle_in();
        sample();
        check("t4_ovf_pulse",  128'(ovf_err_w[0]), 128'(1));
        check("t4_hold_valid", 128'(out_valid_w[0][1]), 128'(1));
        check("t4_hold_data",  128'(out_data_w[0][127:64]), 128'(t4_data[0]));
        adv();
        sample();
        check("t4_ovf_single", 128'(ovf_err_w[0]), 128'(0));
        adv();
        out_ready = 2'b11;
        run(6);
        check("t4_sb_drained", 128'(sbq1.size()), 128'(0));
        check("t4_credits",    128'(cred[0][1] - b1), 128'(4));
        check("t4_ovf_cnt",    128'(oerr[0] - o0), 128'(1));

        // Body flit into an idle VC, then a one-flit packet to (2,3)
        b0 = cred[0][0];
        p0 = perr[0];
        set_flit(1'b0, 1'b0, 1'b0, 64'hDEAD_0000_0000_0041);
        sample();
        adv();
        idle_in();
        sample();
        check("t5_no_valid_n1", 128'(out_valid_w[0][0]), 128'(0));
        adv();
        sample();
        check("t5_proto_pulse", 128'(proto_err_w[0]), 128'(1));
        check("t5_credit_pulse", 128'(credit_w[0][0]), 128'(1));
        check("t5_no_valid_n2", 128'(out_valid_w[0][0]), 128'(0));
        adv();
        run(2);
        check("t5_credit_cnt", 128'(cred[0][0] - b0), 128'(1));
        check("t5_proto_cnt",  128'(perr[0] - p0), 128'(1));
        b0 = cred[0][0];
        set_flit(1'b0, 1'b1, 1'b1, 64'h0F0F_0000_0000_0023);
        push_exp(0, 64'h0F0F_0000_0000_0023, 1'b1, 1'b1, 3'd1);
        sample();
        adv();
        idle_in();
        run(4);
        check("t5_single_drained", 128'(sbq0.size()), 128'(0));
        check("t5_single_credit",  128'(cred[0][0] - b0), 128'(1));

        // Reset in the middle of a stalled packet
        out_ready = 2'b10;
        set_flit(1'b0, 1'b1, 1'b0, 64'hA5A5_0000_0000_0041);
        sample();
        adv();
        set_flit(1'b0, 1'b0, 1'b0, 64'hB0D1_0000_0000_0001);
        sample();
        adv();
        idle_in();
        sample();
        check("t6_pending_valid", 128'(out_valid_w[0][0]), 128'(1));
        adv();
        b0 = cred[0][0];
        noc_rst = 1'b1;
        set_flit(1'b0, 1'b0, 1'b1, 64'hB0D2_0000_0000_0002);
        sample();
        adv();
        sample();
        check("t6_rst_valid",  128'(out_valid_w[0]), 128'(0));
        check("t6_rst_port",   128'(out_port_w[0]),  128'(0));
        check("t6_rst_credit", 128'(credit_w[0]),    128'(0));
        check("t6_rst_errs", 128'({route_err_w[0], proto_err_w[0], ovf_err_w[0]}), 128'(0));
        adv();
        noc_rst   = 1'b0;
        idle_in();
        out_ready = 2'b11;
        run(4);
        sample();
        check("t6_post_valid",   128'(out_valid_w[0]), 128'(0));
        check("t6_post_credits", 128'(cred[0][0] - b0), 128'(0));
        adv();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
